// File: rtl/dff_write_arbiter.sv
// dff_write_arbiter
//   Round-robin write arbiter in front of one shared enable-gated register.
//   N_REQ requesters use a 4-phase req/ack handshake; the winner's data is
//   presented on reg_d with a single-cycle reg_en pulse.
//
// Ports
//   clk     rising-edge clock
//   reset   synchronous, active-high reset
//   req     per-requester write request, held until its ack is seen
//   wdata   requester i data at [i*DATA_W +: DATA_W]
//   reg_q   readback from the shared register
//   grant   one-hot current owner, 0 when idle
//   ack     per-requester write-complete level, held until req drops
//   reg_en  shared register enable, one-cycle pulse per write
//   reg_d   shared register data
//   busy    high whenever the FSM is not idle
//   wr_err  sticky readback-mismatch flag
//
// Build option
//   WRITE_VERIFY_EN : adds a VERIFY cycle comparing reg_q with reg_d before
//                     ack; without it wr_err is constant 0.
//
// state  | meaning
// IDLE   | no owner; arbitrate among asserted req bits
// WRITE  | reg_en pulse cycle, register captures reg_d at the next edge
// VERIFY | compare readback with written data (WRITE_VERIFY_EN only)
// ACK    | ack held for the owner until its req drops

module dff_write_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]         reg_q,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          ack,
  output logic                      reg_en,
  output logic [DATA_W-1:0]         reg_d,
  output logic                      busy,
  output logic                      wr_err
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     win_q, win_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic                 reg_en_q, reg_en_d;
  logic [DATA_W-1:0]    reg_d_q, reg_d_d;
  logic                 busy_q, busy_d;
  logic                 wr_err_q, wr_err_d;

  logic [PTR_W-1:0]     pick_idx;
  logic                 pick_vld;
  logic [PTR_W-1:0]     cand_idx;
  int                   cand;

  // Scan ptr, ptr+1, ... (mod N_REQ); first asserted request wins.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand     = (int'(ptr_q) + off) % N_REQ;
      cand_idx = PTR_W'(cand);
      if (!pick_vld && req[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    grant_d  = grant_q;
    ack_d    = ack_q;
    reg_en_d = 1'b0;
    reg_d_d  = reg_d_q;
    busy_d   = busy_q;
    wr_err_d = wr_err_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          win_d           = pick_idx;
          grant_d         = '0;
          grant_d[pick_idx] = 1'b1;
          reg_d_d         = wdata[int'(pick_idx)*DATA_W +: DATA_W];
          reg_en_d        = 1'b1;
          busy_d          = 1'b1;
          state_d         = ST_WRITE;
        end
      end

      ST_WRITE: begin
`ifdef WRITE_VERIFY_EN
        state_d = ST_VERIFY;
`else
        ack_d        = '0;
        ack_d[win_q] = 1'b1;
        state_d      = ST_ACK;
`endif
      end

`ifdef WRITE_VERIFY_EN
      ST_VERIFY: begin
        wr_err_d     = wr_err_q | (reg_q != reg_d_q);
        ack_d        = '0;
        ack_d[win_q] = 1'b1;
        state_d      = ST_ACK;
      end
`endif

      ST_ACK: begin
        // An owner that dropped req before ack still gets a one-cycle ack.
        if (!req[win_q]) begin
          ack_d   = '0;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      reg_en_q <= 1'b0;
      reg_d_q  <= '0;
      busy_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      reg_en_q <= reg_en_d;
      reg_d_q  <= reg_d_d;
      busy_q   <= busy_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign grant  = grant_q;
  assign ack    = ack_q;
  assign reg_en = reg_en_q;
  assign reg_d  = reg_d_q;
  assign busy   = busy_q;

`ifdef WRITE_VERIFY_EN
  assign wr_err = wr_err_q;
`else
  // Readback is only consulted by the verify path.
  logic unused_reg_q;
  assign unused_reg_q = ^reg_q;
  assign wr_err       = 1'b0;
`endif

endmodule

// File: tb/tb_dff_write_arbiter.sv
module tb_dff_write_arbiter;
  localparam int N = 4;
  localparam int W = 8;
`ifdef WRITE_VERIFY_EN
  localparam int ACK_STAGE = 2;
  localparam bit VERIFY    = 1'b1;
`else
  localparam int ACK_STAGE = 1;
  localparam bit VERIFY    = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [W-1:0]   reg_q;
  logic [N-1:0]   grant, ack;
  logic           reg_en, busy, wr_err;
  logic [W-1:0]   reg_d;

  always #5 clk = ~clk;

  dff_write_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata), .reg_q(reg_q),
    .grant(grant), .ack(ack), .reg_en(reg_en), .reg_d(reg_d),
    .busy(busy), .wr_err(wr_err)
  );

  int total = 0;
  int bad   = 0;

  // reference model: owner index, cycles since grant, rotating priority
  int           m_owner = -1;
  int           m_stage = 0;
  int           m_ptr   = 0;
  logic [N-1:0] e_grant = '0, e_ack = '0;
  logic         e_en = 1'b0, e_busy = 1'b0, e_err = 1'b0;
  logic [W-1:0] e_d = '0;
  logic [W-1:0] reg_store = '0;
  bit           force_zero = 1'b0;
  int           waits[N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int off = 0; off < N; off++)
      if (r[(p + off) % N]) return (p + off) % N;
    return -1;
  endfunction

  task automatic step();
    logic           r;
    logic [N-1:0]   rv;
    logic [N*W-1:0] wd;
    logic [W-1:0]   rq, d_pre;
    logic           en_pre;
    r = reset; rv = req; wd = wdata; rq = reg_q; en_pre = reg_en; d_pre = reg_d;
    @(posedge clk);
    #1;
    // shared register environment
    if (r) reg_store = '0;
    else if (en_pre === 1'b1) reg_store = d_pre;
    reg_q = force_zero ? '0 : reg_store;
    // model
    if (r) begin
      m_owner = -1; m_ptr = 0; e_grant = '0; e_ack = '0;
      e_en = 1'b0; e_d = '0; e_busy = 1'b0; e_err = 1'b0;
    end else if (m_owner < 0) begin
      e_en = 1'b0;
      if (rv != '0) begin
        m_owner = pick(rv, m_ptr);
        m_stage = 0;
        e_grant = '0; e_grant[m_owner] = 1'b1;
        e_d = wd[m_owner*W +: W];
        e_en = 1'b1; e_busy = 1'b1;
      end
    end else if (m_stage < ACK_STAGE) begin
      e_en = 1'b0;
      if (VERIFY && m_stage == 1) e_err = e_err | (rq != e_d);
      m_stage++;
      if (m_stage == ACK_STAGE) e_ack[m_owner] = 1'b1;
    end else if (!rv[m_owner]) begin
      m_ptr = (m_owner + 1) % N;
      m_owner = -1; e_grant = '0; e_ack = '0; e_busy = 1'b0;
    end
    chk("grant",  32'(grant),  32'(e_grant));
    chk("ack",    32'(ack),    32'(e_ack));
    chk("reg_en", 32'(reg_en), 32'(e_en));
    chk("reg_d",  32'(reg_d),  32'(e_d));
    chk("busy",   32'(busy),   32'(e_busy));
    chk("wr_err", 32'(wr_err), 32'(e_err));
    // fairness: a held request waits for fewer than N grants to others
    for (int i = 0; i < N; i++) begin
      if (r || !rv[i]) waits[i] = 0;
      else if (reg_en === 1'b1) begin
        if (grant[i] === 1'b1) waits[i] = 0;
        else begin
          waits[i]++;
          chk("fair_wait", 32'(waits[i] < N), 32'd1);
        end
      end
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 20 && busy !== 1'b0; n++) step();
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_write(input int idx, input logic [W-1:0] data);
    req[idx] = 1'b1;
    wdata[idx*W +: W] = data;
    for (int n = 0; n < 10 && ack[idx] !== 1'b1; n++) step();
    chk("write_ack_timeout", 32'(ack[idx]), 32'd1);
    req[idx] = 1'b0;
    wait_idle();
  endtask

  int grants_q[$];
  int exp_order[5];
  bit rearm[N];
  int drop_dly[N], idle_cnt[N];
  int ack_cnt;

  initial begin
    // 1: reset with all requests pending
    reset = 1'b1; req = 4'b1111; wdata = 32'h44332211; reg_q = '0;
    for (int i = 0; i < N; i++) waits[i] = 0;
    step();
    step();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step();
    chk("rel_busy", 32'(busy), 32'd1);
    chk("rel_grant", 32'(grant), 32'b0001);
    req = '0;
    wait_idle();

    // 2: single write from requester 2
    req = 4'b0100; wdata[2*W +: W] = 8'hA5;
    step();
    chk("t2_grant", 32'(grant), 32'b0100);
    chk("t2_en", 32'(reg_en), 32'd1);
    chk("t2_d", 32'(reg_d), 32'hA5);
    for (int s = 0; s < ACK_STAGE; s++) step();
    chk("t2_en_off", 32'(reg_en), 32'd0);
    chk("t2_ack", 32'(ack), 32'b0100);
    req = '0;
    step();
    chk("t2_ack_drop", 32'(ack), 32'd0);
    chk("t2_busy", 32'(busy), 32'd0);

    // 3: round robin from ptr 0
    reset = 1'b1; step(); reset = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < N; i++) rearm[i] = 1'b0;
    for (int n = 0; n < 80 && grants_q.size() < 5; n++) begin
      step();
      if (reg_en === 1'b1)
        for (int i = 0; i < N; i++) if (grant[i] === 1'b1) grants_q.push_back(i);
      for (int i = 0; i < N; i++) begin
        if (req[i] && ack[i] === 1'b1) begin req[i] = 1'b0; rearm[i] = 1'b1; end
        else if (rearm[i]) begin req[i] = 1'b1; rearm[i] = 1'b0; end
      end
    end
    exp_order = '{0, 1, 2, 3, 0};
    for (int g = 0; g < 5; g++)
      chk("rr_order", (g < grants_q.size()) ? 32'(grants_q[g]) : 32'hFFFF_FFFF, 32'(exp_order[g]));
    req = '0;
    wait_idle();

    // 4: early drop by requester 1
    req = 4'b0010; wdata[1*W +: W] = 8'h5A;
    step();
    chk("t4_grant", 32'(grant), 32'b0010);
    chk("t4_d", 32'(reg_d), 32'h5A);
    req = '0; wdata[1*W +: W] = 8'h00;
    ack_cnt = 0;
    for (int n = 0; n < 6; n++) begin
      step();
      if (ack[1] === 1'b1) ack_cnt++;
    end
    chk("t4_ack_pulse", 32'(ack_cnt), 32'd1);
    chk("t4_d_hold", 32'(reg_d), 32'h5A);
    req = 4'b1011;
    step();
    chk("t4_next_grant", 32'(grant), 32'b1000);

    // 5: reset while owner 3 is in ack
    for (int n = 0; n < 6 && ack[3] !== 1'b1; n++) step();
    chk("t5_ack3", 32'(ack), 32'b1000);
    reset = 1'b1; req = 4'b1001;
    step();
    chk("t5_grant0", 32'(grant), 32'd0);
    chk("t5_ack0", 32'(ack), 32'd0);
    chk("t5_d0", 32'(reg_d), 32'd0);
    reset = 1'b0;
    step();
    chk("t5_grant", 32'(grant), 32'b0001);
    req = '0;
    wait_idle();

`ifdef WRITE_VERIFY_EN
    // 6: readback mismatch is sticky
    force_zero = 1'b1;
    do_write(2, 8'h3C);
    chk("t6_err", 32'(wr_err), 32'd1);
    force_zero = 1'b0;
    do_write(0, 8'h11);
    chk("t6_err_sticky", 32'(wr_err), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("t6_err_clr", 32'(wr_err), 32'd0);
`else
    do_write(2, 8'h3C);
    chk("t6_err_off", 32'(wr_err), 32'd0);
`endif

    // random requesters against the model
    req = '0;
    for (int i = 0; i < N; i++) begin drop_dly[i] = 0; idle_cnt[i] = $urandom_range(0, 3); end
    for (int n = 0; n < 800; n++) begin
      step();
      reset = ($urandom_range(0, 199) == 0);
      wdata = $urandom;
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (ack[i] === 1'b1) begin
            if (drop_dly[i] == 0) begin req[i] = 1'b0; idle_cnt[i] = $urandom_range(0, 3); end
            else drop_dly[i]--;
          end
        end else if (idle_cnt[i] == 0) begin
          req[i] = 1'b1; drop_dly[i] = $urandom_range(0, 2);
        end else idle_cnt[i]--;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
